// File: rtl/arbiter_bus_lv1_lv2.sv
// Shared lv1<->lv2 bus arbiter.
// One processor-side owner at a time, picked round-robin. While the owner
// holds the bus, snoop responders on other cores are granted one at a time
// with a single idle cycle between snoop grants. A hold counter flags owners
// that keep the bus for TIMEOUT_CYC cycles; the grant itself is never revoked.
module arbiter_bus_lv1_lv2 #(
    parameter int NUM_CORES   = 4,
    parameter int CORE_ID_WID = 2,
    parameter int TIMEOUT_CYC = 1024,
    parameter int TMR_WID     = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CORES-1:0]   bus_lv1_lv2_req_proc,
    input  logic [NUM_CORES-1:0]   bus_lv1_lv2_req_snoop,
    output logic [NUM_CORES-1:0]   bus_lv1_lv2_gnt_proc,
    output logic [NUM_CORES-1:0]   bus_lv1_lv2_gnt_snoop,
    output logic [CORE_ID_WID-1:0] proc_owner,
    output logic                   arb_timeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PROC  = 2'd1;
    localparam logic [1:0] ST_SNOOP = 2'd2;

    localparam logic [TMR_WID-1:0] HOLD_MAX = TMR_WID'(TIMEOUT_CYC);

    logic [1:0]             state_q,     state_d;
    logic [CORE_ID_WID-1:0] rr_ptr_q,    rr_ptr_d;
    logic [CORE_ID_WID-1:0] owner_q,     owner_d;
    logic [CORE_ID_WID-1:0] snp_q,       snp_d;      // current snoop grantee
    logic [CORE_ID_WID-1:0] snp_ptr_q,   snp_ptr_d;  // where the next snoop search starts
    logic [NUM_CORES-1:0]   gnt_proc_q,  gnt_proc_d;
    logic [NUM_CORES-1:0]   gnt_snoop_q, gnt_snoop_d;
    logic [TMR_WID-1:0]     hold_q,      hold_d;
    logic                   timeout_q,   timeout_d;
    logic [NUM_CORES-1:0]   snp_mask;

    // Index after idx, wrapping at NUM_CORES (works for non power-of-two counts).
    function automatic logic [CORE_ID_WID-1:0] next_idx(input logic [CORE_ID_WID-1:0] idx);
        return (int'(idx) == NUM_CORES - 1) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [NUM_CORES-1:0] onehot(input logic [CORE_ID_WID-1:0] idx);
        logic [NUM_CORES-1:0] r;
        for (int i = 0; i < NUM_CORES; i++) r[i] = (i == int'(idx));
        return r;
    endfunction

    // First set bit of v at or after start, wrapping; scanned backwards so the
    // closest candidate to start is the last one written.
    function automatic logic [CORE_ID_WID-1:0] rr_pick(input logic [NUM_CORES-1:0]   v,
                                                       input logic [CORE_ID_WID-1:0] start);
        logic [CORE_ID_WID-1:0] r;
        int k;
        r = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            k = (int'(start) + i) % NUM_CORES;
            if (v[k]) r = CORE_ID_WID'(k);
        end
        return r;
    endfunction

    // The owner can never be its own snoop responder.
    assign snp_mask = bus_lv1_lv2_req_snoop & ~onehot(owner_q);

    // Next-state, grant and hold-counter logic.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        snp_d       = snp_q;
        snp_ptr_d   = snp_ptr_q;
        gnt_proc_d  = gnt_proc_q;
        gnt_snoop_d = gnt_snoop_q;
        hold_d      = hold_q;
        timeout_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Snoop requests are ignored here: no snoop without an owner.
                gnt_proc_d  = '0;
                gnt_snoop_d = '0;
                hold_d      = '0;
                if (|bus_lv1_lv2_req_proc) begin
                    owner_d    = rr_pick(bus_lv1_lv2_req_proc, rr_ptr_q);
                    gnt_proc_d = onehot(owner_d);
                    snp_ptr_d  = next_idx(owner_d);
                    hold_d     = TMR_WID'(1);
                    state_d    = ST_PROC;
                end
            end
            ST_PROC: begin
                if (!bus_lv1_lv2_req_proc[owner_q]) begin
                    // Release; IDLE then serves as the one-cycle bus turnaround.
                    gnt_proc_d = '0;
                    rr_ptr_d   = next_idx(owner_q);
                    hold_d     = '0;
                    state_d    = ST_IDLE;
                end else if (|snp_mask) begin
                    snp_d       = rr_pick(snp_mask, snp_ptr_q);
                    gnt_snoop_d = onehot(snp_d);
                    state_d     = ST_SNOOP;
                end
            end
            ST_SNOOP: begin
                // The owner keeps gnt_proc until the snoop finishes, even if it
                // has already dropped its request; PROC then releases it.
                if (!bus_lv1_lv2_req_snoop[snp_q]) begin
                    gnt_snoop_d = '0;
                    snp_ptr_d   = next_idx(snp_q);
                    state_d     = ST_PROC;
                end
            end
            default: begin
                gnt_proc_d  = '0;
                gnt_snoop_d = '0;
                hold_d      = '0;
                state_d     = ST_IDLE;
            end
        endcase

        // Count grant cycles while the owner keeps the bus, saturating.
        if (state_q != ST_IDLE && (|gnt_proc_d))
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;

        // Registered pulse lands in the grant cycle where the count first hits the limit.
        timeout_d = (|gnt_proc_d) && (hold_d == HOLD_MAX) && (hold_q != HOLD_MAX);
    end

    // State and output registers; reset drops every grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            snp_q       <= '0;
            snp_ptr_q   <= '0;
            gnt_proc_q  <= '0;
            gnt_snoop_q <= '0;
            hold_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            snp_q       <= snp_d;
            snp_ptr_q   <= snp_ptr_d;
            gnt_proc_q  <= gnt_proc_d;
            gnt_snoop_q <= gnt_snoop_d;
            hold_q      <= hold_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus_lv1_lv2_gnt_proc  = gnt_proc_q;
    assign bus_lv1_lv2_gnt_snoop = gnt_snoop_q;
    assign proc_owner            = owner_q;
    assign arb_timeout           = timeout_q;

endmodule

// File: tb/tb_arbiter_bus_lv1_lv2.sv
// Directed bench for the lv1<->lv2 bus arbiter. Inputs change and outputs are
// sampled 1ns after each rising edge.
module tb_arbiter_bus_lv1_lv2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_proc = '0;
    logic [3:0] req_snoop = '0;
    logic [3:0] gnt_proc;
    logic [3:0] gnt_snoop;
    logic [1:0] owner;
    logic       tmo;

    int vecs = 0;
    int errs = 0;

    arbiter_bus_lv1_lv2 #(
        .NUM_CORES(4), .CORE_ID_WID(2), .TIMEOUT_CYC(8), .TMR_WID(4)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .bus_lv1_lv2_req_proc (req_proc),
        .bus_lv1_lv2_req_snoop(req_snoop),
        .bus_lv1_lv2_gnt_proc (gnt_proc),
        .bus_lv1_lv2_gnt_snoop(gnt_snoop),
        .proc_owner           (owner),
        .arb_timeout          (tmo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_proc = '0;
        req_snoop = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] hot;
        int order[5] = '{0, 1, 2, 3, 0};

        // Reset values
        do_reset();
        chk("rst_gnt_proc", gnt_proc, 4'b0000);
        chk("rst_gnt_snoop", gnt_snoop, 4'b0000);
        chk("rst_owner", owner, 2'd0);
        chk("rst_timeout", tmo, 1'b0);

        // 1: single requester, release, then rr pointer moves to 2
        req_proc = 4'b0010;
        tick();
        chk("t1_gnt", gnt_proc, 4'b0010);
        chk("t1_owner", owner, 2'd1);
        req_proc = 4'b0000;
        tick();
        chk("t1_release", gnt_proc, 4'b0000);
        req_proc = 4'b1111;
        tick();
        chk("t1_rr_next", gnt_proc, 4'b0100);
        chk("t1_rr_owner", owner, 2'd2);
        req_proc = 4'b0000;
        tick();
        chk("t1_release2", gnt_proc, 4'b0000);

        // 2: all request, each owner holds 3 cycles -> 0,1,2,3,0 with idle gaps
        do_reset();
        req_proc = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            hot = 4'b0001 << order[g];
            tick();
            chk("t2_gnt", gnt_proc, hot);
            chk("t2_owner", owner, order[g][1:0]);
            tick();
            tick();
            chk("t2_hold", gnt_proc, hot);
            req_proc = 4'b1111 & ~hot;
            tick();
            chk("t2_idle_gap", gnt_proc, 4'b0000);
            req_proc = 4'b1111;
        end
        req_proc = 4'b0000;
        tick();
        chk("t2_idle", gnt_proc, 4'b0000);

        // 3: owner 2, snoop 1101 -> snoop 3 then 0, core 2 masked
        req_proc = 4'b0100;
        tick();
        chk("t3_owner", gnt_proc, 4'b0100);
        req_snoop = 4'b1101;
        tick();
        chk("t3_snp3", gnt_snoop, 4'b1000);
        chk("t3_proc_a", gnt_proc, 4'b0100);
        tick();
        chk("t3_snp3_hold", gnt_snoop, 4'b1000);
        req_snoop = 4'b0101;
        tick();
        chk("t3_gap", gnt_snoop, 4'b0000);
        chk("t3_proc_b", gnt_proc, 4'b0100);
        tick();
        chk("t3_snp0", gnt_snoop, 4'b0001);
        chk("t3_proc_c", gnt_proc, 4'b0100);
        req_snoop = 4'b0100;
        tick();
        chk("t3_snp0_drop", gnt_snoop, 4'b0000);
        tick();
        chk("t3_owner_masked", gnt_snoop, 4'b0000);
        chk("t3_proc_d", gnt_proc, 4'b0100);
        req_snoop = 4'b0000;
        req_proc = 4'b0000;
        tick();
        chk("t3_release", gnt_proc, 4'b0000);

        // 4: owner 0 drops req while snoop 2 active -> held until snoop ends
        req_proc = 4'b0001;
        tick();
        chk("t4_owner", gnt_proc, 4'b0001);
        req_snoop = 4'b0100;
        tick();
        chk("t4_snp", gnt_snoop, 4'b0100);
        req_proc = 4'b0000;
        tick();
        chk("t4_proc_held", gnt_proc, 4'b0001);
        chk("t4_snp_held", gnt_snoop, 4'b0100);
        tick();
        chk("t4_proc_held2", gnt_proc, 4'b0001);
        req_snoop = 4'b0000;
        tick();
        chk("t4_snp_drop", gnt_snoop, 4'b0000);
        chk("t4_proc_still", gnt_proc, 4'b0001);
        tick();
        chk("t4_proc_drop", gnt_proc, 4'b0000);

        // 5: timeout after 8 grant cycles, single pulse, grant kept
        req_proc = 4'b0010;
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk("t5_gnt", gnt_proc, 4'b0010);
            chk("t5_timeout", tmo, (c == 8) ? 1'b1 : 1'b0);
        end
        req_proc = 4'b0000;
        tick();
        chk("t5_release", gnt_proc, 4'b0000);
        chk("t5_timeout_off", tmo, 1'b0);

        // 6: reset in SNOOP clears grants at once; first grant after from core 0
        req_proc = 4'b1000;
        tick();
        chk("t6_owner", gnt_proc, 4'b1000);
        req_snoop = 4'b0001;
        tick();
        chk("t6_snp", gnt_snoop, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_proc", gnt_proc, 4'b0000);
        chk("t6_rst_snoop", gnt_snoop, 4'b0000);
        chk("t6_rst_owner", owner, 2'd0);
        req_proc = 4'b0000;
        req_snoop = 4'b0000;
        tick();
        rst_n = 1'b1;
        req_proc = 4'b1111;
        tick();
        chk("t6_first_gnt", gnt_proc, 4'b0001);
        chk("t6_first_owner", owner, 2'd0);
        req_proc = 4'b0000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
